// File: rtl/press_pkg.sv
// Shared types and helpers for the multi-channel key-press processor.
package press_pkg;
  localparam int COUNT_W  = 8;
  localparam int MAX_CH   = 16;
  localparam int CH_IDX_W = 4;

  typedef enum logic {ARB_NONE, ARB_OWN} arb_state_e;
  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  function automatic logic [4:0] popcount(input logic [MAX_CH-1:0] vec);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_CH; i++) n = n + {4'd0, vec[i]};
    return n;
  endfunction

  function automatic logic is_onehot(input logic [MAX_CH-1:0] vec);
    return popcount(vec) == 5'd1;
  endfunction

  function automatic ch_idx_t onehot_to_idx(input logic [MAX_CH-1:0] vec);
    ch_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) if (vec[i]) idx = idx | ch_idx_t'(i);
    return idx;
  endfunction
endpackage

// File: rtl/press_filter.sv
// One key channel: SYNC_STAGES-deep synchroniser followed by a debounce counter
// that only moves filt after DEBOUNCE_CYCLES consecutive differing samples.
module press_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   sync_ext;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sync;

  assign sync_ext = {sync_q, raw};
  assign sync_d   = sync_ext[SYNC_STAGES-1:0];
  assign sync     = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      filt_d = sync;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
endmodule

// File: rtl/multi_press_processor.sv
// N-channel key-press arbiter: debounced keys become one-hot single-cycle press pulses.
// Optional per-channel saturating press counters are enabled by MULTI_PRESS_COUNT_EN.
module multi_press_processor
  import press_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         key_raw,
  output logic [NUM_CH-1:0]         press_pulse,
  output logic [ID_W-1:0]           press_id,
  output logic                      press_valid,
  output logic                      collision,
  output logic                      owner_valid,
`ifdef MULTI_PRESS_COUNT_EN
  output logic [NUM_CH*COUNT_W-1:0] press_count,
`endif
  output logic [ID_W-1:0]           owner_id
);
  logic [NUM_CH-1:0] filt;
  logic [MAX_CH-1:0] filt_ext;
  logic              onehot, multi;
  ch_idx_t           hot_idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    press_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk  (clk),
      .reset(reset),
      .raw  (key_raw[i]),
      .filt (filt[i])
    );
  end

  assign filt_ext = MAX_CH'(filt);
  assign onehot   = is_onehot(filt_ext);
  assign hot_idx  = onehot_to_idx(filt_ext);
  assign multi    = popcount(filt_ext) >= 5'd2;

  arb_state_e        state_q, state_d;
  ch_idx_t           owner_q, owner_d;
  logic              fire;
  logic [NUM_CH-1:0] pulse_d, pulse_q;
  logic [ID_W-1:0]   id_d, id_q;
  logic              coll_d, coll_q, multi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_NONE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // A one-hot vector fires unless it is the key we already own; multi-key holds.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (filt_ext == '0) begin
      state_d = ARB_NONE;
    end else if (onehot && !(state_q == ARB_OWN && owner_q == hot_idx)) begin
      state_d = ARB_OWN;
      owner_d = hot_idx;
    end
  end

  always_comb begin
    fire    = onehot && !(state_q == ARB_OWN && owner_q == hot_idx);
    pulse_d = fire ? filt : '0;
    id_d    = fire ? ID_W'(hot_idx) : '0;
    coll_d  = multi && !multi_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_q <= '0;
      id_q    <= '0;
      coll_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      id_q    <= id_d;
      coll_q  <= coll_d;
      multi_q <= multi;
    end
  end

  assign press_pulse = pulse_q;
  assign press_id    = id_q;
  assign press_valid = |pulse_q;
  assign collision   = coll_q;
  assign owner_valid = (state_q == ARB_OWN);
  assign owner_id    = ID_W'(owner_q);

`ifdef MULTI_PRESS_COUNT_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    logic [COUNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else if (pulse_d[i] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign press_count[i*COUNT_W +: COUNT_W] = cnt_q;
  end
`endif
endmodule
